// File: rtl/cordic_pkg.sv
// Shared CORDIC constants and state encoding, used by both the vectoring
// (rect-to-polar) and rotation (polar-to-rect) engines.
package cordic_pkg;

    // atan(2^-i) as binary angles where 2^16 corresponds to a full turn
    localparam logic [15:0] ATAN_TABLE [16] = '{
        16'h2000, 16'h12E4, 16'h09FB, 16'h0511,
        16'h028B, 16'h0146, 16'h00A3, 16'h0051,
        16'h0029, 16'h0014, 16'h000A, 16'h0005,
        16'h0003, 16'h0001, 16'h0001, 16'h0000
    };

    localparam int          CORDIC_K_Q15 = 19898;
    localparam logic [15:0] PHASE_PI     = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cordic_microrot.sv
// Single combinational CORDIC micro-rotation. Vectoring mode steers y toward 0;
// rotation mode steers z toward 0.
module cordic_microrot
    import cordic_pkg::*;
#(
    parameter int W  = 21,
    parameter int ZW = 16
) (
    input  logic signed [W-1:0]  x_in,
    input  logic signed [W-1:0]  y_in,
    input  logic        [ZW-1:0] z_in,
    input  logic        [3:0]    iter,
    input  logic                 vectoring,
    output logic signed [W-1:0]  x_out,
    output logic signed [W-1:0]  y_out,
    output logic        [ZW-1:0] z_out
);

    logic signed [W-1:0] x_sh;
    logic signed [W-1:0] y_sh;
    logic        [ZW-1:0] atan_v;
    logic                 rot_ccw;

    always_comb begin
        x_sh    = x_in >>> iter;
        y_sh    = y_in >>> iter;
        atan_v  = ZW'(ATAN_TABLE[iter]);
        // counter-clockwise step (d=+1) when y is negative or residual angle is positive
        rot_ccw = vectoring ? y_in[W-1] : ~z_in[ZW-1];
        if (rot_ccw) begin
            x_out = x_in - y_sh;
            y_out = y_in + x_sh;
            z_out = z_in - atan_v;
        end else begin
            x_out = x_in + y_sh;
            y_out = y_in - x_sh;
            z_out = z_in + atan_v;
        end
    end

endmodule

// File: rtl/cordic_vectoring_seq.sv
// Iterative CORDIC vectoring engine: one micro-rotation per clock, converting
// (x, y) into gain-compensated magnitude and binary-angle phase.
module cordic_vectoring_seq
    import cordic_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int N_ITER = 16,
    parameter int GUARD  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] y_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] mag_out,
    output logic [DATA_W-1:0] phase_out
);

    localparam int W  = DATA_W + 3 + GUARD;
    localparam int PW = W + 16;

    state_t              state_q, state_d;
    logic signed [W-1:0] x_q, x_d, y_q, y_d;
    logic [DATA_W-1:0]   z_q, z_d;
    logic [3:0]          i_q, i_d;
    logic                zero_q, zero_d;
    logic [DATA_W-1:0]   mag_q, mag_d, phase_q, phase_d;

    logic signed [W-1:0] x_ext, y_ext, x_rot, y_rot;
    logic [DATA_W-1:0]   z_rot;
    logic [PW-1:0]       prod, scaled;

    // inputs carried with GUARD fractional bits and 3 bits of integer headroom
    assign x_ext = {{3{x_in[DATA_W-1]}}, x_in, {GUARD{1'b0}}};
    assign y_ext = {{3{y_in[DATA_W-1]}}, y_in, {GUARD{1'b0}}};

    cordic_microrot #(.W(W), .ZW(DATA_W)) u_microrot (
        .x_in      (x_q),
        .y_in      (y_q),
        .z_in      (z_q),
        .iter      (i_q),
        .vectoring (1'b1),
        .x_out     (x_rot),
        .y_out     (y_rot),
        .z_out     (z_rot)
    );

    assign prod   = PW'(x_q[W-2:0]) * PW'(CORDIC_K_Q15) + (PW'(1) << (14 + GUARD));
    assign scaled = prod >> (15 + GUARD);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign mag_out   = mag_q;
    assign phase_out = phase_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        zero_d  = zero_q;
        mag_d   = mag_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // pre-rotate left-half-plane vectors by pi so iterations converge
                    if (x_in[DATA_W-1]) begin
                        x_d = -x_ext;
                        y_d = -y_ext;
                        z_d = DATA_W'(PHASE_PI);
                    end else begin
                        x_d = x_ext;
                        y_d = y_ext;
                        z_d = '0;
                    end
                    zero_d  = (x_in == '0) && (y_in == '0);
                    i_d     = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                x_d = x_rot;
                y_d = y_rot;
                z_d = z_rot;
                i_d = i_q + 4'd1;
                if (i_q == 4'(N_ITER - 1)) begin
                    state_d = SCALE;
                end
            end
            SCALE: begin
                if (zero_q || x_q[W-1]) begin
                    mag_d = '0;
                end else if (scaled > PW'({DATA_W{1'b1}})) begin
                    mag_d = '1;
                end else begin
                    mag_d = scaled[DATA_W-1:0];
                end
                phase_d = zero_q ? '0 : z_q;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            zero_q  <= 1'b0;
            mag_q   <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            zero_q  <= zero_d;
            mag_q   <= mag_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: tb/tb_cordic_vectoring_seq.sv
// Self-checking bench for cordic_vectoring_seq: directed corner vectors, handshake
// stalls, reset mid-iteration and randomized vectors against a real-arithmetic model.
module tb_cordic_vectoring_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x_in = '0;
    logic [15:0] y_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] mag_out;
    logic [15:0] phase_out;

    int errCount = 0;
    int checkCount = 0;

    cordic_vectoring_seq #(.DATA_W(16), .N_ITER(16), .GUARD(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .phase_out (phase_out)
    );

    always #5 clk = ~clk;

    // Compares with a tolerance; wrap treats values as 16-bit angles modulo a full turn
    task automatic checkOutput(input string tag, input int obs, input int exp,
                               input int tol, input bit wrap);
        int d;
        checkCount++;
        d = obs - exp;
        if (wrap) begin
            d = d & 32'hFFFF;
            if (d >= 32768) d = d - 65536;
        end
        if (d > tol || d < -tol) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Ideal polar conversion: rounded Euclidean magnitude and atan2 as a binary angle
    function automatic void refModel(input int x, input int y, output int mag, output int ph);
        real r;
        real a;
        if (x == 0 && y == 0) begin
            mag = 0;
            ph  = 0;
        end else begin
            r   = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
            a   = $atan2(real'(y), real'(x)) * 32768.0 / 3.141592653589793;
            mag = int'(r);
            ph  = int'(a) & 32'hFFFF;
        end
    endfunction

    // Sends one vector, checks latency, optional output stall, results and handshake return
    task automatic applyStimulus(input int x, input int y, input int holdCycles,
                                 input bit pulseIter, input bit simulIn);
        int n;
        int mRef;
        int pRef;
        int tol;
        refModel(x, y, mRef, pRef);
        tol = (mRef == 0) ? 0 : 3;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("in_ready_idle", int'(in_ready), 1, 0, 0);
        x_in = 16'(x);
        y_in = 16'(y);
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("in_ready_busy", int'(in_ready), 0, 0, 0);
        n = 0;
        while (!out_valid && n < 40) begin
            if (pulseIter && n == 3) begin
                in_valid = 1'b1;
                x_in = 16'($urandom);
                y_in = 16'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        checkOutput("latency", n, 17, 0, 0);
        checkOutput($sformatf("mag(%0d,%0d)", x, y), int'(mag_out), mRef, tol, 0);
        if (mRef == 0 || mRef >= 1024)
            checkOutput($sformatf("phase(%0d,%0d)", x, y), int'(phase_out), pRef, tol, 1);
        for (int k = 0; k < holdCycles; k++) begin
            @(posedge clk); #1;
            checkOutput("hold_valid", int'(out_valid), 1, 0, 0);
            checkOutput("hold_in_ready", int'(in_ready), 0, 0, 0);
            checkOutput("hold_mag", int'(mag_out), mRef, tol, 0);
            checkOutput("hold_phase", int'(phase_out), pRef, tol, 1);
        end
        out_ready = 1'b1;
        if (simulIn) begin
            in_valid = 1'b1;
            x_in = 16'd123;
            y_in = 16'd456;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        checkOutput("out_valid_drop", int'(out_valid), 0, 0, 0);
        checkOutput("in_ready_back", int'(in_ready), 1, 0, 0);
    endtask

    initial begin
        int seen;
        int rx;
        int ry;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", int'(in_ready), 1, 0, 0);
        checkOutput("rst_out_valid", int'(out_valid), 0, 0, 0);
        checkOutput("rst_mag", int'(mag_out), 0, 0, 0);
        checkOutput("rst_phase", int'(phase_out), 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(1000, 0, 0, 0, 0);
        applyStimulus(0, 1000, 0, 0, 0);
        applyStimulus(0, -1000, 0, 0, 0);
        applyStimulus(-1000, 0, 0, 0, 0);
        applyStimulus(-707, -707, 0, 0, 0);
        applyStimulus(-32768, -32768, 0, 0, 0);
        applyStimulus(32767, 32767, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(300, -4000, 10, 1, 1);
        applyStimulus(-20000, 15000, 2, 1, 0);

        // Abort a vector after five micro-rotations; outputs still hold the previous result
        x_in = 16'd5000;
        y_in = 16'd3000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_mag", int'(mag_out), 0, 0, 0);
        checkOutput("midrst_phase", int'(phase_out), 0, 0, 0);
        checkOutput("midrst_out_valid", int'(out_valid), 0, 0, 0);
        checkOutput("midrst_in_ready", int'(in_ready), 1, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checkOutput("midrst_no_valid", seen, 0, 0, 0);
        applyStimulus(5000, 3000, 0, 0, 0);

        for (int k = 0; k < 12; k++) begin
            if (k < 6) begin
                rx = int'($signed(16'($urandom)));
                ry = int'($signed(16'($urandom)));
            end else begin
                rx = int'($urandom_range(4000)) - 2000;
                ry = int'($urandom_range(4000)) - 2000;
            end
            applyStimulus(rx, ry, k % 3, k[0], k[1]);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
